// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton load-strobe front end.
package btn_pkg;

    // Per-channel press/repeat state, kept as plain constants so legacy tools can read it.
    typedef logic [1:0] btn_state_t;

    localparam btn_state_t StIdle   = 2'd0;
    localparam btn_state_t StHeld   = 2'd1;
    localparam btn_state_t StRepeat = 2'd2;

    // Default timing, in 1 ms ticks.
    localparam int unsigned DEF_STABLE_TICKS = 16;
    localparam int unsigned DEF_REPEAT_DELAY = 500;
    localparam int unsigned DEF_REPEAT_RATE  = 100;

    // Width of a counter that must reach value-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, tick-based debounce, press/auto-repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic RST,
    input  logic tick_i,
    input  logic btn_i,
    input  logic repeat_en_i,
    output logic load_o,
    output logic level_o
);

    localparam int unsigned DbW    = cnt_width(STABLE_TICKS);
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RptW   = cnt_width(RptMax);

    localparam logic [DbW-1:0]  DbLast    = DbW'(STABLE_TICKS - 1);
    localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    btn_state_t      state_q, state_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RptW-1:0] rpt_last;
    logic            load_q, load_d;

    // Synchroniser: raw button is asynchronous, second stage is the usable sample.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
    end

    // Debounce: level flips only after the synced input disagrees for STABLE_TICKS ticks.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (tick_i) begin
            if (db_cnt_q == DbLast) begin
                level_d  = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Press/repeat FSM: pulse on the debounced rising edge, then after DELAY and every RATE ticks.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        load_d    = 1'b0;
        rpt_last  = (state_q == StHeld) ? DelayLast : RateLast;
        if (!level_q) begin
            // Release (or never pressed) always returns to idle without a pulse.
            state_d   = StIdle;
            rpt_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d   = StHeld;
                    rpt_cnt_d = '0;
                    load_d    = 1'b1;
                end
                StHeld, StRepeat: begin
                    if (!repeat_en_i) begin
                        // Disabling repeat restarts the full initial delay once re-enabled.
                        state_d   = StHeld;
                        rpt_cnt_d = '0;
                    end else if (tick_i) begin
                        if (rpt_cnt_q == rpt_last) begin
                            state_d   = StRepeat;
                            rpt_cnt_d = '0;
                            load_d    = 1'b1;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = StIdle;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= StIdle;
            rpt_cnt_q <= '0;
            load_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            load_q    <= load_d;
        end
    end

    assign load_o  = load_q;
    assign level_o = level_q;

endmodule

// File: rtl/btn_load_ctrl.sv
// Multi-channel button front end: shared 1 ms tick edge detector plus N_CH independent channels.
module btn_load_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned N_CH         = 3,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            clk_1ms,
    input  logic [N_CH-1:0] btn_in,
    input  logic            repeat_en,
    output logic [N_CH-1:0] load_out,
    output logic [N_CH-1:0] btn_level
);

    logic clk_1ms_q, clk_1ms_d;
    logic tick;

    // Tick is the rising edge of the divider bit; delayed copy resets high so no tick at release.
    always_comb begin
        clk_1ms_d = clk_1ms;
        tick      = clk_1ms & ~clk_1ms_q;
    end

    // Divider-bit delay register.
    always_ff @(posedge clk) begin
        if (RST) begin
            clk_1ms_q <= 1'b1;
        end else begin
            clk_1ms_q <= clk_1ms_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .RST         (RST),
            .tick_i      (tick),
            .btn_i       (btn_in[g]),
            .repeat_en_i (repeat_en),
            .load_o      (load_out[g]),
            .level_o     (btn_level[g])
        );
    end

endmodule

// File: doc/btn_load_ctrl.md
# btn_load_ctrl

Multi-channel pushbutton/switch front end that produces the one-cycle `Load` strobes consumed by the 4-bit register bank. Each channel synchronises a raw input, debounces it on the 1 ms tick, emits a single-cycle load pulse on each debounced press, and can optionally auto-repeat while the input is held. It replaces per-channel load generators with one parameterised block sitting between the board switches and the register `Load` inputs.

## Interface
- `N_CH`, default 3: number of independent channels (A, B, C).
- `STABLE_TICKS`, default 16: ticks an input must differ from its debounced level before the level flips.
- `REPEAT_DELAY`, default 500: ticks from the press pulse to the first repeat pulse.
- `REPEAT_RATE`, default 100: ticks between subsequent repeat pulses.

- `clk` input, 1: system clock; the only clock.
- `RST` input, 1: synchronous, active-high reset.
- `clk_1ms` input, 1: divider output bit as a level; sampled on `clk`.
- `btn_in` input, N_CH: raw, asynchronous switch/button levels.
- `repeat_en` input, 1: global auto-repeat enable; synchronous to `clk`.
- `load_out` output, N_CH: one-cycle load strobe per channel.
- `btn_level` output, N_CH: debounced level per channel.

## Operation
- Reset values: sync flops 0, `clk_1ms_d` 1, debounce counters 0, `btn_level` 0, repeat counters 0, state IDLE, `load_out` 0.
- Tick generation: `tick = clk_1ms & ~clk_1ms_d`, with `clk_1ms_d` registered. A high `clk_1ms` at reset release gives no tick.
- Synchroniser: two flops per channel; `btn_s` is the second stage.
- Debounce, per channel, each cycle:
  - If `btn_s == btn_level`, set cnt to 0.
  - Else, on tick: if cnt == STABLE_TICKS-1, set `btn_level <= btn_s` and cnt to 0; otherwise increment cnt.
  - With no tick, cnt holds.
- Per-channel FSM states:
  - IDLE: `btn_level` is 0.
  - HELD: waiting REPEAT_DELAY.
  - REPEAT: periodic pulses.
- FSM transitions:
  - IDLE→HELD on rising `btn_level`. Pulse `load_out`, clear the repeat counter.
  - HELD: on tick with `repeat_en`, increment. At REPEAT_DELAY-1 go to REPEAT, pulse, clear.
  - REPEAT: on tick with `repeat_en`, increment. At REPEAT_RATE-1, pulse and clear.
  - Any state → IDLE when `btn_level` is 0. No pulse on release.
  - `repeat_en`=0 in HELD or REPEAT: go to HELD, clear the counter.
- Channels are fully independent. Several `load_out` bits may assert in the same cycle.
- Counter widths: `$clog2(param)` bits, minimum 1. Counters never exceed param-1 and never wrap.
- A button held through reset is seen as a fresh press STABLE_TICKS ticks after release of `RST`.

## Timing
- `load_out` is registered and lasts exactly one `clk` cycle per event. It asserts the cycle after `btn_level` rises.
- Press latency: 2 sync cycles, plus STABLE_TICKS ticks, plus 1 cycle.
- Repeat pulses land 1 cycle after the qualifying tick.
- `RST` asserted mid-operation: all outputs 0 in the following cycle. No pulse is emitted in the reset cycle.

## Structure
- Package `btn_pkg`: FSM state typedef (IDLE, HELD, REPEAT) and default constants for the tick parameters.
- Sub-module `btn_channel`: synchroniser, debounce, FSM and repeat counter for one input. It is instantiated N_CH times via generate.
- The top level holds only tick generation and the generate loop.

## Test plan
Bench parameters: STABLE_TICKS=4, REPEAT_DELAY=8, REPEAT_RATE=3. `clk_1ms` has a 10-clk period.
- Clean press: ch0 0→1, held 20 ticks, `repeat_en`=0. Expect one 1-cycle `load_out[0]`; `btn_level[0]` rises on the 4th tick after sync.
- Bounce: ch1 toggles every tick for 3 ticks, then stays high. Expect exactly one pulse. A separate 3-tick glitch gives no pulse and no level change.
- Repeat: `repeat_en`=1, ch0 held 18 ticks after the press pulse. Expect pulses at press, +8, +11, +14 and +17 ticks (5 total). Release gives no pulse.
- Simultaneous: ch0 and ch2 rise in the same cycle. Expect `load_out`=3'b101 in one cycle.
- Repeat gating: in REPEAT, drop `repeat_en` for 5 ticks, then restore it. Expect no pulses while low, then the first pulse 8 ticks after restore.
- Reset mid-REPEAT with the button held: outputs are 0 the next cycle. After reset, expect `btn_level` to rise and a press pulse 4 ticks later.
